// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN widths, FC classifier state type and score saturation
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int N_CH    = 12;
    localparam int N_POS   = 16;
    localparam int N_CLASS = 10;
    localparam int ACC_W   = 40;

    localparam logic signed [DATA_W-1:0] SCORE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_EMIT,
        S_DONE
    } fc_state_t;

    // Clamp a wide signed value into DATA_W: in range only if all bits above the
    // DATA_W sign bit agree with it, otherwise pin to the rail matching its sign.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] top;
        top = v[ACC_W-1:DATA_W-1];
        return (top == '0 || top == '1) ? v[DATA_W-1:0] : (v[ACC_W-1] ? SCORE_MIN : SCORE_MAX);
    endfunction

endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed multiply-accumulate with synchronous clear and enable
module fc_mac
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = a * b;

    // Accumulate the sign-extended full-precision product; clear wins over enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

endmodule

// File: rtl/fc_classify.sv
// fc_classify: fully-connected 192->10 output stage with per-class scores and argmax
module fc_classify
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [3:0]               feat_ch,
    output logic [3:0]               feat_pos,
    input  logic signed [DATA_W-1:0] feat_data,
    output logic [10:0]              w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic signed [DATA_W-1:0] score,
    output logic [3:0]               score_class,
    output logic                     score_valid,
    output logic [3:0]               digit,
    output logic                     busy,
    output logic                     done
);

    fc_state_t                state, state_nx;
    logic                     armed;
    logic                     fetch_d;
    logic                     start_go;
    logic                     acc_clr;
    logic                     last_feat;
    logic                     last_class;
    logic [3:0]               cls;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] sat_score;
    logic signed [DATA_W-1:0] best;

    assign last_feat   = (feat_ch == 4'(N_CH-1)) && (feat_pos == 4'(N_POS-1));
    assign last_class  = (cls == 4'(N_CLASS-1));
    assign sat_score   = saturate(acc >>> FRAC_W);
    assign score       = score_valid ? sat_score : '0;
    assign score_class = score_valid ? cls : '0;

    // Operand data lags its address by one cycle, so accumulate on the cycle after FETCH
    fc_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .en    (fetch_d),
        .a     (feat_data),
        .b     (w_data),
        .acc   (acc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and status decode; start is only honoured once a cycle has passed since reset
    always_comb begin
        state_nx    = state;
        score_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        start_go    = 1'b0;
        acc_clr     = 1'b0;
        unique case (state)
            S_IDLE: begin
                start_go = start && armed;
                acc_clr  = start_go;
                state_nx = start_go ? S_FETCH : S_IDLE;
            end
            S_FETCH: begin
                busy     = 1'b1;
                state_nx = last_feat ? S_LAST : S_FETCH;
            end
            S_LAST: begin
                busy     = 1'b1;
                state_nx = S_EMIT;
            end
            S_EMIT: begin
                busy        = 1'b1;
                score_valid = 1'b1;
                acc_clr     = !last_class;
                state_nx    = last_class ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                start_go = start && armed;
                acc_clr  = start_go;
                state_nx = start_go ? S_FETCH : S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address walk, class counter and running argmax
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            fetch_d  <= 1'b0;
            feat_ch  <= '0;
            feat_pos <= '0;
            w_addr   <= '0;
            cls      <= '0;
            best     <= SCORE_MIN;
            digit    <= '0;
        end else begin
            armed   <= 1'b1;
            fetch_d <= (state == S_FETCH);
            if (start_go) begin
                feat_ch  <= '0;
                feat_pos <= '0;
                w_addr   <= '0;
                cls      <= '0;
                best     <= SCORE_MIN;
                digit    <= '0;
            end else if (state == S_FETCH && !last_feat) begin
                feat_pos <= (feat_pos == 4'(N_POS-1)) ? '0 : feat_pos + 4'd1;
                feat_ch  <= (feat_pos == 4'(N_POS-1)) ? feat_ch + 4'd1 : feat_ch;
                w_addr   <= w_addr + 11'd1;
            end else if (state == S_EMIT) begin
                feat_ch  <= '0;
                feat_pos <= '0;
                w_addr   <= last_class ? w_addr : w_addr + 11'd1;
                cls      <= last_class ? cls : cls + 4'd1;
                if (sat_score > best) begin
                    best  <= sat_score;
                    digit <= cls;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_classify.sv
// tb_fc_classify: randomized scoreboard bench for the FC classifier
module tb_fc_classify;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        feat_ch, feat_pos, score_class, digit;
    logic signed [15:0] feat_data = '0;
    logic signed [15:0] w_data = '0;
    logic signed [15:0] score;
    logic [10:0]       w_addr;
    logic              score_valid, busy, done;

    fc_classify dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .feat_ch     (feat_ch),
        .feat_pos    (feat_pos),
        .feat_data   (feat_data),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .score       (score),
        .score_class (score_class),
        .score_valid (score_valid),
        .digit       (digit),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic signed [15:0] fm [192];
    logic signed [15:0] wm [1920];

    // Synchronous memories: one cycle from address to data
    always @(posedge clk) begin
        feat_data <= (feat_ch < 4'd12) ? fm[int'(feat_ch) * 16 + int'(feat_pos)] : 16'sd0;
        w_data    <= (w_addr < 11'd1920) ? wm[w_addr] : 16'sd0;
    end

    typedef struct {
        int cls;
        int score;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   s_base = 0;
    int   addr_err = 0;
    int   exp_digit = 0;
    bit   run_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: dot product per class, floor-rescale, clamp, first strict maximum
    task automatic build_expected();
        int best;
        best = -32768;
        exp_digit = 0;
        for (int k = 0; k < 10; k++) begin
            longint s;
            longint sh;
            int sc;
            exp_t e;
            s = 0;
            for (int i = 0; i < 192; i++)
                s += longint'(fm[i]) * longint'(wm[k*192 + i]);
            sh = s >>> 8;
            sc = (sh > 32767) ? 32767 : (sh < -32768) ? -32768 : int'(sh);
            if (sc > best) begin
                best = sc;
                exp_digit = k;
            end
            e.cls = k;
            e.score = sc;
            e.cyc = 194 * k + 194;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic signed [15:0] rnd(input int lo, input int hi);
        return 16'(int'($urandom_range(hi - lo)) + lo);
    endfunction

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < 192; i++) fm[i] = rnd(lo, hi);
        for (int i = 0; i < 1920; i++) wm[i] = rnd(lo, hi);
    endtask

    // Monitor: address walk, score scoreboard and completion
    always @(negedge clk) begin
        int c, j, k, idx;
        exp_t e;
        c = cyc - s_base;
        if (reset && run_on && c >= 1 && c <= 1940) begin
            j = (c - 1) % 194;
            k = (c - 1) / 194;
            if (j <= 192) begin
                idx = (j < 192) ? j : 191;
                if (int'(feat_ch) != idx / 16 || int'(feat_pos) != idx % 16 || int'(w_addr) != k * 192 + idx)
                    addr_err++;
            end
        end
        if (reset && score_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_score_valid class=%0d score=%0d expected=none", score_class, score);
            end else begin
                e = exp_q.pop_front();
                chk("score_class", int'(score_class), e.cls);
                chk("score", int'(score), e.score);
                chk("score_cycle", c, e.cyc);
            end
        end
        if (reset && run_on && c > 0 && done) begin
            chk("done_cycle", c, 1941);
            chk("digit", int'(digit), exp_digit);
            chk("addr_seq_errors", addr_err, 0);
            chk("scores_outstanding", exp_q.size(), 0);
            run_on = 1'b0;
        end
    end

    task automatic run_start();
        build_expected();
        @(negedge clk);
        start = 1'b1;
        s_base = cyc;
        addr_err = 0;
        run_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_after_start", int'(done), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (run_on && n < 2100) begin
            @(negedge clk);
            n++;
        end
        if (run_on) begin
            checks++;
            failures++;
            $display("FAIL done_timeout waited=%0d cycles required=done by 1941", n);
            run_on = 1'b0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(score_valid), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_digit"}, int'(digit), 0);
        chk({tag, "_ch"}, int'(feat_ch), 0);
        chk({tag, "_pos"}, int'(feat_pos), 0);
        chk({tag, "_waddr"}, int'(w_addr), 0);
    endtask

    initial begin
        for (int i = 0; i < 192; i++) fm[i] = '0;
        for (int i = 0; i < 1920; i++) wm[i] = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // 1: unit features, weights k*0.01 -> rising scores, argmax 9
        for (int i = 0; i < 192; i++) fm[i] = 16'sh0100;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < 192; i++) wm[k*192 + i] = 16'(k * 256 / 100);
        run_start();
        wait_done();
        chk("t1_digit", int'(digit), 9);

        // 2: only class 3 weights nonzero, features 0.5 -> score 96.0
        for (int i = 0; i < 192; i++) fm[i] = 16'sh0080;
        for (int i = 0; i < 1920; i++) wm[i] = (i / 192 == 3) ? 16'sh0100 : 16'sh0000;
        run_start();
        wait_done();
        chk("t2_digit", int'(digit), 3);

        // 3: identical rows on classes 2 and 7 -> tie resolves to 2
        for (int i = 0; i < 192; i++) fm[i] = rnd(1, 255);
        for (int i = 0; i < 192; i++) begin
            logic signed [15:0] w;
            w = rnd(1, 255);
            for (int k = 0; k < 10; k++) wm[k*192 + i] = (k == 2 || k == 7) ? w : 16'sh0000;
        end
        run_start();
        wait_done();
        chk("t3_digit", int'(digit), 2);

        // 4: saturation at both rails
        for (int i = 0; i < 192; i++) fm[i] = 16'sh7FFF;
        for (int i = 0; i < 1920; i++) wm[i] = 16'sh7FFF;
        run_start();
        wait_done();
        for (int i = 0; i < 1920; i++) wm[i] = 16'sh8001;
        run_start();
        wait_done();

        // 5: reset mid-run, start coincident with release ignored, then fresh run
        fill_random(-512, 511);
        run_start();
        repeat (499) @(negedge clk);
        reset = 1'b0;
        run_on = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_idle("midrun_reset");
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_release_busy", int'(busy), 0);
        fill_random(-512, 511);
        run_start();
        wait_done();

        // 6: start pulses while busy are ignored; start in DONE restarts
        fill_random(-1024, 1023);
        run_start();
        for (int p = 0; p < 3; p++) begin
            repeat (int'($urandom_range(600, 200))) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        repeat (4) @(negedge clk);
        chk("done_held", int'(done), 1);
        fill_random(-32768, 32767);
        run_start();
        wait_done();

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
